// File: rtl/posedge_counter_rate_meter.sv
// posedge_counter_rate_meter: brings up to eight asynchronous 32-bit edge counts into axi_clk
// and publishes per-window deltas as a coherent set with a one-cycle valid strobe.
module posedge_counter_rate_meter #(
    parameter int NUM_SIG     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_TRIES   = 8
) (
    input  logic        axi_clk,
    input  logic        axi_reset,
    input  logic        enable,
    input  logic [31:0] window_cycles,
    input  logic [31:0] count_0,
    input  logic [31:0] count_1,
    input  logic [31:0] count_2,
    input  logic [31:0] count_3,
    input  logic [31:0] count_4,
    input  logic [31:0] count_5,
    input  logic [31:0] count_6,
    input  logic [31:0] count_7,
    output logic [31:0] rate_0,
    output logic [31:0] rate_1,
    output logic [31:0] rate_2,
    output logic [31:0] rate_3,
    output logic [31:0] rate_4,
    output logic [31:0] rate_5,
    output logic [31:0] rate_6,
    output logic [31:0] rate_7,
    output logic        rate_valid,
    output logic [31:0] window_count,
    output logic        busy,
    output logic        capture_timeout
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] PUBLISH  = 2'd3;
    localparam logic [2:0] CH_LAST  = 3'(NUM_SIG - 1);
    localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);

    logic [31:0] cnt_in [8];
    logic [31:0] sync_q [8][SYNC_STAGES];
    logic [31:0] sync_d [8][SYNC_STAGES];
    logic [31:0] hold_q [8], hold_d [8];
    logic [31:0] cur_q [8], cur_d [8];
    logic [31:0] prev_q [8], prev_d [8];
    logic [31:0] rate_q [8], rate_d [8];
    logic [1:0]  state_q, state_d;
    logic [31:0] timer_q, timer_d, win_len_q, win_len_d, wcount_q, wcount_d;
    logic [2:0]  ch_q, ch_d;
    logic [7:0]  tries_q, tries_d;
    logic        baseline_q, baseline_d, timeout_q, timeout_d, valid_q, valid_d;
    logic [31:0] sel_sync, win_clamp;
    logic        stable;

    assign cnt_in = '{count_0, count_1, count_2, count_3, count_4, count_5, count_6, count_7};

    // Inactive channels are tied off so their rate stays 0 and their logic trims away.
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            sync_d[c][0] = (c < NUM_SIG) ? cnt_in[c] : '0;
            for (int s = 1; s < SYNC_STAGES; s++) sync_d[c][s] = sync_q[c][s-1];
            hold_d[c] = sync_q[c][SYNC_STAGES-1];
        end
    end

    assign sel_sync  = sync_q[ch_q][SYNC_STAGES-1];
    assign stable    = sel_sync == hold_q[ch_q];
    assign win_clamp = (window_cycles < 32'd128) ? 32'd128 : window_cycles;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        win_len_d  = win_len_q;
        ch_d       = ch_q;
        tries_d    = tries_q;
        baseline_d = baseline_q;
        timeout_d  = timeout_q;
        wcount_d   = wcount_q;
        valid_d    = 1'b0;
        cur_d      = cur_q;
        prev_d     = prev_q;
        rate_d     = rate_q;
        if (state_q == IDLE) begin
            timer_d    = '0;
            baseline_d = 1'b0;
            ch_d       = '0;
            tries_d    = '0;
            if (enable) begin
                state_d   = RUN;
                win_len_d = win_clamp;
            end
        end else if (!enable) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            timer_d = timer_q + 32'd1;
            if (timer_q == win_len_q - 32'd1) begin
                state_d = CAPTURE;
                ch_d    = '0;
                tries_d = '0;
            end
        end else if (state_q == CAPTURE) begin
            // A channel that never settles is taken as-is so the window still publishes.
            if (stable || tries_q == TRY_LAST) begin
                cur_d[ch_q] = sel_sync;
                timeout_d   = timeout_q | !stable;
                tries_d     = '0;
                ch_d        = ch_q + 3'd1;
                state_d     = (ch_q == CH_LAST) ? PUBLISH : CAPTURE;
            end else begin
                tries_d = tries_q + 8'd1;
            end
        end else begin
            state_d    = RUN;
            timer_d    = '0;
            win_len_d  = win_clamp;
            baseline_d = 1'b1;
            prev_d     = cur_q;
            if (baseline_q) begin
                for (int c = 0; c < 8; c++) rate_d[c] = cur_q[c] - prev_q[c];
                valid_d  = 1'b1;
                wcount_d = wcount_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            sync_q     <= '{default: '0};
            hold_q     <= '{default: '0};
            cur_q      <= '{default: '0};
            prev_q     <= '{default: '0};
            rate_q     <= '{default: '0};
            state_q    <= IDLE;
            timer_q    <= '0;
            win_len_q  <= '0;
            wcount_q   <= '0;
            ch_q       <= '0;
            tries_q    <= '0;
            baseline_q <= 1'b0;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            hold_q     <= hold_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            rate_q     <= rate_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            win_len_q  <= win_len_d;
            wcount_q   <= wcount_d;
            ch_q       <= ch_d;
            tries_q    <= tries_d;
            baseline_q <= baseline_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
        end
    end

    assign rate_0          = rate_q[0];
    assign rate_1          = rate_q[1];
    assign rate_2          = rate_q[2];
    assign rate_3          = rate_q[3];
    assign rate_4          = rate_q[4];
    assign rate_5          = rate_q[5];
    assign rate_6          = rate_q[6];
    assign rate_7          = rate_q[7];
    assign rate_valid      = valid_q;
    assign window_count    = wcount_q;
    assign busy            = state_q != IDLE;
    assign capture_timeout = timeout_q;
endmodule

// File: tb/tb_posedge_counter_rate_meter.sv
// tb_posedge_counter_rate_meter: directed checks of windowing, counter wrap, instability,
// window clamp, abort/re-enable and a three-channel build.
module tb_posedge_counter_rate_meter;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, en3 = 1'b0;
    logic [31:0] wc_cfg = 32'd1000;
    logic [31:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0, c4 = '0, c5 = '0, c6 = '0, c7 = '0;
    logic [31:0] r [8], r3 [8];
    logic [31:0] wc, wc3;
    logic        rv, rv3, busy, busy3, to, to3;
    int          n_chk = 0, n_pass = 0, pulses = 0, pulses3 = 0;
    bit          inc0 = 1'b0, tog2 = 1'b0, tog5 = 1'b0;

    always #5 clk = ~clk;

    posedge_counter_rate_meter u_dut (
        .axi_clk(clk), .axi_reset(rst), .enable(en), .window_cycles(wc_cfg),
        .count_0(c0), .count_1(c1), .count_2(c2), .count_3(c3),
        .count_4(c4), .count_5(c5), .count_6(c6), .count_7(c7),
        .rate_0(r[0]), .rate_1(r[1]), .rate_2(r[2]), .rate_3(r[3]),
        .rate_4(r[4]), .rate_5(r[5]), .rate_6(r[6]), .rate_7(r[7]),
        .rate_valid(rv), .window_count(wc), .busy(busy), .capture_timeout(to)
    );

    posedge_counter_rate_meter #(.NUM_SIG(3)) u_dut3 (
        .axi_clk(clk), .axi_reset(rst), .enable(en3), .window_cycles(wc_cfg),
        .count_0(c0), .count_1(c1), .count_2(c2), .count_3(c3),
        .count_4(c4), .count_5(c5), .count_6(c6), .count_7(c7),
        .rate_0(r3[0]), .rate_1(r3[1]), .rate_2(r3[2]), .rate_3(r3[3]),
        .rate_4(r3[4]), .rate_5(r3[5]), .rate_6(r3[6]), .rate_7(r3[7]),
        .rate_valid(rv3), .window_count(wc3), .busy(busy3), .capture_timeout(to3)
    );

    always @(negedge clk) begin
        if (rv) pulses++;
        if (rv3) pulses3++;
    end

    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #2;
            if (inc0) begin
                div++;
                if (div == 10) begin
                    c0  = c0 + 32'd1;
                    div = 0;
                end
            end
            if (tog2) c2 = ~c2;
            if (tog5) c5 = ~c5;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit which, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(which ? rv3 : rv) && cyc < budget);
        chk(which ? "pulse3_seen" : "pulse_seen", {31'd0, which ? rv3 : rv}, 32'd1);
    endtask

    initial begin
        int cyc, p;
        repeat (3) tick();
        chk("rst_rate0", r[0], 32'd0);
        chk("rst_wcount", wc, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, rv}, 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_pulses", 32'(pulses), 32'd0);

        // Steady rate on channel 0, wrapping counter on channel 1, instability on channel 2.
        c1   = 32'hFFFF_FFF0;
        inc0 = 1'b1;
        en   = 1'b1;
        chk("busy_pre", {31'd0, busy}, 32'd0);
        tick();
        chk("busy_rise", {31'd0, busy}, 32'd1);
        repeat (1509) tick();
        chk("baseline_no_pulse", 32'(pulses), 32'd0);
        c1 = c1 + 32'h20;
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) tog2 = 1'b1;
            wait_pulse(1'b0, 1500, cyc);
            tog2 = 1'b0;
            chk("wcount", wc, 32'(k));
            chk("rate1_wrap", r[1], 32'h20);
            if (k <= 3) chk("rate0_range", {31'd0, r[0] >= 32'd99 && r[0] <= 32'd101}, 32'd1);
            chk("timeout_flag", {31'd0, to}, {31'd0, k >= 4});
            repeat (500) tick();
            c1 = c1 + 32'h20;
        end

        // Asynchronous reset mid-RUN, checked before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rate0", r[0], 32'd0);
        chk("arst_rate1", r[1], 32'd0);
        chk("arst_wcount", wc, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_timeout", {31'd0, to}, 32'd0);
        inc0 = 1'b0;
        en   = 1'b0;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_pulses", 32'(pulses), 32'd5);

        // Clamp to 128 RUN cycles, then abort during CAPTURE and re-enable.
        wc_cfg = 32'd5;
        en     = 1'b1;
        wait_pulse(1'b0, 400, cyc);
        chk("clamp_wcount1", wc, 32'd1);
        c3 = c3 + 32'd5;
        wait_pulse(1'b0, 300, cyc);
        chk("clamp_period", 32'(cyc), 32'd137);
        chk("clamp_rate3", r[3], 32'd5);
        chk("clamp_wcount2", wc, 32'd2);
        repeat (128) tick();
        chk("abort_busy_capture", {31'd0, busy}, 32'd1);
        en = 1'b0;
        tick();
        chk("abort_idle", {31'd0, busy}, 32'd0);
        p = pulses;
        repeat (150) tick();
        chk("abort_no_pulse", 32'(pulses), 32'(p));
        chk("abort_wcount_hold", wc, 32'd2);
        chk("abort_rate3_hold", r[3], 32'd5);
        c3 = c3 + 32'd5;
        en = 1'b1;
        repeat (200) tick();
        chk("reenable_baseline", 32'(pulses), 32'(p));
        wait_pulse(1'b0, 200, cyc);
        chk("reenable_wcount", wc, 32'd3);
        chk("reenable_rate3", r[3], 32'd0);

        // Three-channel build ignores a toggling channel 5.
        en   = 1'b0;
        tog5 = 1'b1;
        en3  = 1'b1;
        wait_pulse(1'b1, 400, cyc);
        wait_pulse(1'b1, 300, cyc);
        chk("ns3_period", 32'(cyc), 32'd132);
        chk("ns3_rate5", r3[5], 32'd0);
        chk("ns3_timeout", {31'd0, to3}, 32'd0);
        chk("ns3_wcount", wc3, 32'd2);
        tog5 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
